// File: rtl/dj_path_tracer.sv
// dj_path_tracer: rebuilds the route from start_node to end_node out of the
// solver's predecessor table and streams it out, start node first, over
// a valid/ready handshake.
// Optional per-node distance reporting: define DJ_PATH_DIST_EN.
//
// state | meaning
// IDLE  | table writable, waiting for start
// WALK  | following predecessors back from end_node, one push per clock
// EMIT  | streaming LIFO top-first (start node first)
// FIN   | one-cycle done pulse, then back to IDLE

module dj_path_tracer #(
  parameter int N_NODES = 13,
  parameter int NODE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we,
  input  logic [NODE_W-1:0] tbl_addr,
  input  logic [NODE_W-1:0] tbl_pred,
  input  logic              tbl_vld,
`ifdef DJ_PATH_DIST_EN
  input  logic [7:0]        tbl_dist,
`endif
  input  logic              start,
  input  logic [NODE_W-1:0] start_node,
  input  logic [NODE_W-1:0] end_node,
  output logic              busy,
  output logic [NODE_W-1:0] path_node,
  output logic              path_valid,
  input  logic              path_ready,
  output logic              path_last,
  output logic [NODE_W:0]   path_len,
`ifdef DJ_PATH_DIST_EN
  output logic [7:0]        path_dist,
`endif
  output logic              done,
  output logic              err
);

  // Storage is sized to the full index space so every NODE_W-bit index is
  // legal; entries at or above N_NODES are simply never written.
  localparam int DEPTH = 1 << NODE_W;

  localparam logic [NODE_W:0] CNT_ONE  = (NODE_W+1)'(1);
  localparam logic [NODE_W:0] CNT_TWO  = (NODE_W+1)'(2);
  localparam logic [NODE_W:0] CNT_FULL = (NODE_W+1)'(N_NODES);
  localparam logic [NODE_W:0] CNT_LAST = (NODE_W+1)'(N_NODES - 1);

  typedef enum logic [1:0] {IDLE, WALK, EMIT, FIN} state_t;

  state_t            state;
  logic [NODE_W-1:0] pred_mem [DEPTH];
  logic [DEPTH-1:0]  vld_bits;
  logic [NODE_W-1:0] lifo_node [DEPTH];
  logic [NODE_W-1:0] start_q;
  logic [NODE_W-1:0] cur;
  logic [NODE_W:0]   sp;

`ifdef DJ_PATH_DIST_EN
  logic [7:0]        dist_mem [DEPTH];
  logic [7:0]        lifo_dist [DEPTH];
`endif

  logic              tbl_wr;
  logic              cur_is_start;
  logic              cur_vld;
  logic              push_fills;
  logic              start_ok;
  logic [NODE_W-1:0] push_idx;
  logic [NODE_W-1:0] top_idx;
  logic [NODE_W-1:0] next_idx;

  function automatic logic in_range(input logic [NODE_W-1:0] node);
    return {1'b0, node} < CNT_FULL;
  endfunction

  assign tbl_wr       = (state == IDLE) && tbl_we && in_range(tbl_addr);
  assign cur_is_start = (cur == start_q);
  // Out-of-range predecessors land on never-written slots, so they read as
  // invalid and abort the walk.
  assign cur_vld      = vld_bits[cur];
  // This push makes the LIFO full; a further push would mean a loop.
  assign push_fills   = (sp == CNT_LAST);
  assign start_ok     = in_range(start_node) && in_range(end_node);
  assign push_idx     = NODE_W'(sp);
  assign top_idx      = NODE_W'(sp - CNT_ONE);
  assign next_idx     = NODE_W'(sp - CNT_TWO);

  // Table payload; only the valid bits need a reset value.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      pred_mem[tbl_addr] <= tbl_pred;
`ifdef DJ_PATH_DIST_EN
      dist_mem[tbl_addr] <= tbl_dist;
`endif
    end
  end

  // Per-node valid bits, cleared on reset so a fresh table starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_bits <= '0;
    end else if (tbl_wr) begin
      vld_bits[tbl_addr] <= tbl_vld;
    end
  end

  // LIFO storage: every WALK cycle pushes cur at the stack pointer.
  always_ff @(posedge clk) begin
    if (state == WALK) begin
      lifo_node[push_idx] <= cur;
`ifdef DJ_PATH_DIST_EN
      // The start node is the origin, so its distance is 0 by definition.
      lifo_dist[push_idx] <= cur_is_start ? 8'd0 : dist_mem[cur];
`endif
    end
  end

  // Sequencer: accept start, walk predecessors, stream the LIFO, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= '0;
      cur        <= '0;
      sp         <= '0;
      path_len   <= '0;
      busy       <= 1'b0;
      path_valid <= 1'b0;
      path_node  <= '0;
      path_last  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef DJ_PATH_DIST_EN
      path_dist  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            start_q  <= start_node;
            cur      <= end_node;
            sp       <= '0;
            path_len <= '0;
            if (start_ok) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= WALK;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        WALK: begin
          sp       <= sp + CNT_ONE;
          path_len <= path_len + CNT_ONE;
          if (cur_is_start) begin
            state <= EMIT;
          end else if (!cur_vld || push_fills) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cur <= pred_mem[cur];
          end
        end

        EMIT: begin
          if (!path_valid) begin
            // First beat is loaded one clock after the walk ends.
            path_valid <= 1'b1;
            path_node  <= lifo_node[top_idx];
            path_last  <= (sp == CNT_ONE);
`ifdef DJ_PATH_DIST_EN
            path_dist  <= lifo_dist[top_idx];
`endif
          end else if (path_ready) begin
            if (path_last) begin
              path_valid <= 1'b0;
              path_last  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= FIN;
            end else begin
              // Pop and present the entry below in the same clock: no bubble.
              sp        <= sp - CNT_ONE;
              path_node <= lifo_node[next_idx];
              path_last <= (sp == CNT_TWO);
`ifdef DJ_PATH_DIST_EN
              path_dist <= lifo_dist[next_idx];
`endif
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dj_path_tracer.sv
// Bench for dj_path_tracer: directed scenarios followed by random trees,
// each trace compared against a predecessor-chasing reference model.

module tb_dj_path_tracer;

  localparam int N = 13;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tbl_we = 1'b0;
  logic [W-1:0] tbl_addr = '0;
  logic [W-1:0] tbl_pred = '0;
  logic         tbl_vld = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] start_node = '0;
  logic [W-1:0] end_node = '0;
  logic         path_ready = 1'b0;
  logic         busy;
  logic [W-1:0] path_node;
  logic         path_valid;
  logic         path_last;
  logic [W:0]   path_len;
  logic         done;
  logic         err;

  int checks = 0;
  int failures = 0;

  int m_pred [N];
  bit m_vld  [N];

  dj_path_tracer #(.N_NODES(N), .NODE_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_pred   (tbl_pred),
    .tbl_vld    (tbl_vld),
    .start      (start),
    .start_node (start_node),
    .end_node   (end_node),
    .busy       (busy),
    .path_node  (path_node),
    .path_valid (path_valid),
    .path_ready (path_ready),
    .path_last  (path_last),
    .path_len   (path_len),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_pred[i] = 0;
      m_vld[i]  = 1'b0;
    end
  endtask

  task automatic wr(input int a, input int p, input bit v);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = a[W-1:0];
    tbl_pred = p[W-1:0];
    tbl_vld  = v;
    @(negedge clk);
    tbl_we = 1'b0;
    if (a < N) begin
      m_pred[a] = p;
      m_vld[a]  = v;
    end
  endtask

  // Random spanning tree: a shuffled order where each node points at some
  // earlier node; the first node is the root with no predecessor.
  task automatic load_tree(output int root);
    int perm [N];
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    root = perm[0];
    wr(root, 0, 1'b0);
    for (int i = 1; i < N; i++) wr(perm[i], perm[$urandom_range(0, i - 1)], 1'b1);
  endtask

  // mode 0: ready always high, 1: ready toggles, 2: ready random
  task automatic run_trace(input int s, input int e, input int mode);
    int  walk_q [$];
    int  exp_q  [$];
    int  got_q  [$];
    bit  exp_err, range_err, seen_done;
    int  cur, first_valid, done_cyc;
    bit  prev_valid, prev_ready, prev_last;
    logic [W-1:0] prev_node;
    int  spur;

    exp_err = 1'b0;
    range_err = (s >= N) || (e >= N);
    if (range_err) begin
      exp_err = 1'b1;
    end else begin
      cur = e;
      while (1) begin
        walk_q.push_back(cur);
        if (cur == s) break;
        if (!m_vld[cur] || walk_q.size() == N) begin
          exp_err = 1'b1;
          break;
        end
        cur = m_pred[cur];
      end
    end
    if (!exp_err) begin
      for (int i = walk_q.size() - 1; i >= 0; i--) exp_q.push_back(walk_q[i]);
    end

    first_valid = -1;
    done_cyc = -1;
    seen_done = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_last = 1'b0;
    prev_node = '0;
    spur = $urandom_range(0, N - 1);

    @(negedge clk);
    start = 1'b1;
    start_node = s[W-1:0];
    end_node = e[W-1:0];
    path_ready = 1'b0;

    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        chk("busy_after_start", busy, !range_err);
        chk("err_after_start", err, range_err);
        // Table write while busy: must be ignored.
        tbl_we = 1'b1;
        tbl_addr = e[W-1:0];
        tbl_pred = e[W-1:0];
        tbl_vld = (e < N) ? !m_vld[e] : 1'b1;
      end
      if (cyc == 1) begin
        tbl_we = 1'b0;
        if (!range_err) begin
          // Start while busy: must be ignored.
          start = 1'b1;
          start_node = spur[W-1:0];
          end_node = spur[W-1:0];
        end
      end
      if (cyc == 2) start = 1'b0;

      if (prev_valid && !prev_ready) begin
        chk("hold_valid", path_valid, 1);
        chk("hold_node", path_node, prev_node);
        chk("hold_last", path_last, prev_last);
      end

      path_ready = (mode == 0) || (mode == 1 && (cyc % 2) == 0) ||
                   (mode == 2 && $urandom_range(0, 1) == 1);

      if (path_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (path_ready) begin
          got_q.push_back(path_node);
          chk("path_last", path_last, got_q.size() == exp_q.size());
        end
      end
      prev_valid = path_valid;
      prev_ready = path_ready;
      prev_node = path_node;
      prev_last = path_last;
      if (done) begin
        seen_done = 1'b1;
        done_cyc = cyc;
      end
    end

    chk("done_seen", seen_done, 1);
    if (seen_done) begin
      chk("busy_at_done", busy, 0);
      chk("err_at_done", err, exp_err);
    end
    chk("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("beat%0d", i), got_q[i], exp_q[i]);
    if (!exp_err) begin
      chk("first_valid_latency", first_valid, exp_q.size() + 1);
      chk("path_len", path_len, exp_q.size());
    end else if (!range_err) begin
      chk("err_walk_bound", (done_cyc >= 1) && (done_cyc <= N + 1), 1);
    end

    @(negedge clk);
    start = 1'b0;
    tbl_we = 1'b0;
    path_ready = 1'b0;
    chk("done_single_pulse", done, 0);
    chk("err_sticky", err, exp_err);
    chk("valid_after_done", path_valid, 0);
    if (!exp_err) chk("path_len_hold", path_len, exp_q.size());
  endtask

  initial begin
    int root, s, e, a, b, done_cnt;
    bit reached;

    clear_model();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_path_valid", path_valid, 0);
    chk("rst_path_last", path_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_path_node", path_node, 0);
    chk("rst_path_len", path_len, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed: linear chain 10 -> 9 -> 8 -> 2.
    wr(9, 10, 1'b1);
    wr(8, 9, 1'b1);
    wr(2, 8, 1'b1);
    run_trace(10, 2, 0);
    run_trace(10, 2, 1);
    run_trace(5, 5, 0);
    wr(7, 0, 1'b0);
    run_trace(10, 7, 0);
    run_trace(10, 2, 2);
    run_trace(14, 2, 0);
    run_trace(10, 15, 0);
    run_trace(10, 9, 1);
    wr(3, 2, 1'b1);
    wr(2, 3, 1'b1);
    run_trace(10, 3, 2);

    // Reset during EMIT.
    wr(2, 8, 1'b1);
    @(negedge clk);
    start = 1'b1;
    start_node = 4'd10;
    end_node = 4'd2;
    path_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      @(negedge clk);
      if (path_valid) reached = 1'b1;
    end
    chk("reset_test_in_emit", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_busy", busy, 0);
    chk("amid_path_valid", path_valid, 0);
    chk("amid_path_last", path_last, 0);
    chk("amid_path_node", path_node, 0);
    chk("amid_path_len", path_len, 0);
    chk("amid_err", err, 0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("amid_no_done", done_cnt, 0);
    clear_model();
    run_trace(10, 2, 0);

    // Random trees, occasionally with a planted two-node loop.
    for (int it = 0; it < 20; it++) begin
      load_tree(root);
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        wr(a, b, 1'b1);
        wr(b, a, 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
        s = ($urandom_range(0, 1) == 1) ? root : $urandom_range(0, N - 1);
        e = $urandom_range(0, N - 1);
        run_trace(s, e, $urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dj_path_tracer.md
Name: dj_path_tracer

Overview:
- Consumes the shortest-path predecessor table produced by the Dijkstra solver block.
- Reconstructs the route from start_node to end_node by walking predecessors backwards from end_node into an internal LIFO.
- Streams the route out in forward order, start node first, over a valid/ready handshake.
- Sits between the solver and the motion/navigation sequencer.

Parameters:
- N_NODES, 13, number of graph nodes; also the table depth and LIFO depth.
- NODE_W, 4, width of a node index; must satisfy 2**NODE_W >= N_NODES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tbl_we  in  1  write strobe for the predecessor table
- tbl_addr  in  NODE_W  node being written
- tbl_pred  in  NODE_W  predecessor of tbl_addr
- tbl_vld  in  1  1 = tbl_addr has a valid predecessor; 0 = unreached or root
- start  in  1  one-cycle request to trace a path
- start_node  in  NODE_W  source node, sampled with start
- end_node  in  NODE_W  destination node, sampled with start
- busy  out  1  high from accepted start until done
- path_node  out  NODE_W  current path node
- path_valid  out  1  path_node is valid
- path_ready  in  1  downstream accepts path_node
- path_last  out  1  marks the final beat (end_node)
- path_len  out  NODE_W+1  number of nodes in the traced path
- done  out  1  one-cycle completion pulse
- err  out  1  trace failed; sticky

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; all table valid bits cleared.
  - busy, path_valid, path_last, done and err are 0; path_node and path_len are 0.
- Table writes:
  - Accepted only in IDLE; ignored while busy.
  - Addresses >= N_NODES are ignored.
  - One write per cycle.
- States: IDLE, WALK, EMIT, FIN.
- IDLE:
  - start=1 latches start_node/end_node, clears err, clears the LIFO and path_len, and raises busy next cycle.
  - If either node is >= N_NODES: go to FIN with err=1.
  - Otherwise: go to WALK with cur=end_node.
- WALK (one node per clock):
  - Push cur and increment path_len.
  - If cur==start_node: go to EMIT.
  - Else if the valid bit of cur is 0: go to FIN with err=1 (unreachable).
  - Else if the LIFO already holds N_NODES entries: go to FIN with err=1 (cycle in the table).
  - Else: cur = pred[cur].
- Latency: for a path of L nodes, path_valid first rises L+1 clocks after the edge that sampled start.
- EMIT:
  - path_valid=1 and path_node=LIFO top.
  - path_last=1 when the LIFO holds exactly 1 entry.
  - path_node and path_last hold stable while path_ready=0.
  - On path_valid && path_ready: pop; the next node appears the following cycle, with no bubble when path_ready stays high.
  - On the handshake of the last beat: go to FIN.
- FIN:
  - done=1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
- Error paths emit no path beats.
- path_len holds its value until the next accepted start.
- err stays high until the next accepted start or reset.
- start_node==end_node: single beat, path_len=1, path_last=1.
- start while busy: ignored.
- Reset mid-operation: immediate abort to IDLE, table cleared, no done pulse.

Optional Feature:
- Macro: DJ_PATH_DIST_EN.
- When defined, the block adds these ports:
  - tbl_dist  in  8  distance written alongside tbl_pred.
  - path_dist  out  8  distance of path_node from start_node, valid with path_valid.
- Each table entry stores its distance.
- With the feature:
  - path_dist follows the LIFO top.
  - path_dist is 0 on the first beat.
  - path_dist is the stored distance of the end node on the last beat.
  - path_dist resets to 0.
- Without the macro, the ports and the distance storage are absent and behaviour is otherwise identical.

Test Plan:
- Load pred[9]=10, pred[8]=9, pred[2]=8 (all vld=1); start 10→2 with path_ready=1 -> beats 10,9,8,2; path_last on beat 2 only; path_len=4; done pulses once; err=0.
- Same table, path_ready toggled 1/0 every cycle -> same 4 beats; path_node stable while ready=0; no beat lost or duplicated.
- start 5→5 -> single beat 5, path_last=1, path_len=1; done pulses.
- Unreachable end: node 7 vld=0, start 10→7 -> no path_valid; err=1; done pulses; err clears on the next valid start.
- Cycle: pred[3]=2, pred[2]=3, start 10→3 -> err=1 within N_NODES+1 walk cycles; no beats.
- With DJ_PATH_DIST_EN, distances 10:0, 9:1, 8:4, 2:6 -> path_dist 0,1,4,6 on the four beats.
- Separate run: reset asserted during EMIT -> outputs drop to reset values asynchronously, and no done pulse occurs.
